// File: rtl/controle_serializador_if.sv
// Handshake and serial bundle between a parallel producer, the serializer
// controller and a serial consumer.
interface controle_serializador_if #(
   parameter int N = 8
);
   logic [N-1:0] dado;
   logic         valido;
   logic         pronto;
   logic         pausa;
   logic         saida;
   logic         saida_valida;
   logic         fim;
   logic         ocupado;

   modport master (
      output dado, valido, pausa,
      input  pronto, saida, saida_valida, fim, ocupado
   );

   modport slave (
      input  dado, valido, pausa,
      output pronto, saida, saida_valida, fim, ocupado
   );
endinterface

// File: rtl/controle_serializador.sv
// Load/shift/hold controller for an N-bit flip-flop shift chain: accepts a
// word via valid/ready and emits it LSB first, one bit per clock.
module controle_serializador #(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   controle_serializador_if.slave bus
);

   localparam int             CW   = $clog2(N);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   localparam logic [0:0] OCIOSO  = 1'b0;
   localparam logic [0:0] DESLOCA = 1'b1;

   logic [0:0]    state;
   logic [N-1:0]  r;
   logic [CW-1:0] c;

   logic em_desloca;
   logic ultimo;

   assign em_desloca = (state == DESLOCA);
   assign ultimo     = (c == LAST);

   // Pausa masks the last-bit flag, so Pronto cannot open mid-pause.
   assign bus.ocupado      = em_desloca;
   assign bus.saida        = em_desloca & r[0];
   assign bus.saida_valida = em_desloca & ~bus.pausa;
   assign bus.fim          = em_desloca & ~bus.pausa & ultimo;
   assign bus.pronto       = ~em_desloca | bus.fim;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the reset is synchronous and wins over any accept.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= OCIOSO;
         r     <= '0;
         c     <= '0;
      end else begin
         case (state)
            OCIOSO: begin
               if (bus.valido) begin
                  r     <= bus.dado;
                  c     <= '0;
                  state <= DESLOCA;
               end
            end
            DESLOCA: begin
               if (!bus.pausa) begin
                  if (ultimo) begin
                     c <= '0;
                     if (bus.valido) begin
                        r <= bus.dado;
                     end else begin
                        r     <= '0;
                        state <= OCIOSO;
                     end
                  end else begin
                     r <= {1'b0, r[N-1:1]};
                     c <= c + 1'b1;
                  end
               end
            end
            default: begin
               state <= OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: doc/controle_serializador.md
# controle_serializador

Sequencing controller for a shift register built from D flip-flops. It accepts an N-bit parallel word through a valid/ready handshake and drives it out one bit per clock, LSB first. It counts the bits, flags the last one, and supports a pause input that holds the shift. It sits between a parallel producer and any serial consumer in the gate-level library, and it owns the load/shift/hold control of the flip-flop chain.

## Interface
- N, 8: word width in bits; legal N >= 2.
- Clk  in  1  clock; all state changes on the rising edge.
- Rstn  in  1  reset, synchronous, active-low.
- Dado  in  N  parallel word to serialize.
- Valido  in  1  producer has a word on Dado.
- Pronto  out  1  controller can accept a word this cycle.
- Pausa  in  1  when 1, holds the shift; the current bit stays on Saida.
- Saida  out  1  serial data bit.
- SaidaValida  out  1  Saida carries a bit being consumed this cycle.
- Fim  out  1  the current consumed bit is bit N-1 of the word.
- Ocupado  out  1  a word is in progress.

## Operation
- Internal state:
  - shift register R[N-1:0];
  - bit counter C, width clog2(N);
  - FSM with states OCIOSO and DESLOCA.
- OCIOSO:
  - Pronto=1, Ocupado=0, SaidaValida=0, Fim=0, Saida=0.
  - Valido=1 at an edge (accept): R<=Dado, C<=0, go to DESLOCA.
  - Valido=0: stay in OCIOSO.
- DESLOCA:
  - Ocupado=1, Saida=R[0].
  - SaidaValida = ~Pausa.
  - Fim = ~Pausa & (C==N-1).
  - Pronto = Fim. This allows a zero-bubble handoff to the next word.
- Edge in DESLOCA with Pausa=1: R and C unchanged.
- Edge in DESLOCA with Pausa=0 and C<N-1: R <= {1'b0, R[N-1:1]}, C <= C+1.
- Edge in DESLOCA with Pausa=0 and C==N-1:
  - Valido=1: R<=Dado, C<=0, stay in DESLOCA (back-to-back word).
  - Valido=0: R<=0, C<=0, go to OCIOSO.
- Valido while Pronto=0 is ignored. The producer must hold Dado/Valido until the cycle where Pronto=1.
- Dado is sampled only at the accept edge; later changes have no effect on the word in flight.
- C never exceeds N-1; no wrap-around occurs inside a word.
- All outputs are combinational functions of registered state plus Pausa/Valido as listed. There is no combinational path from Dado to any output.

## Timing
- Reset (Rstn=0 at an edge):
  - state OCIOSO, R=0, C=0.
  - From the next cycle: Pronto=1, Ocupado=0, Saida=0, SaidaValida=0, Fim=0.
- Reset overrides everything, including an accept or last-bit edge in the same cycle.
- Reset during DESLOCA aborts the word: no Fim, and the remaining bits are lost.
- Latency with no pauses:
  - word accepted at edge k;
  - bit i on Saida during cycle k+1+i, for i = 0..N-1;
  - Fim=1 during cycle k+N.
- Each Pausa=1 cycle in DESLOCA delays all remaining bits by exactly one cycle.
- Pausa is ignored in OCIOSO.
- Pausa=1 during the last bit masks Fim and Pronto. The bit is repeated until Pausa=0.
- Throughput: one word per N cycles with no idle cycle between words when Valido stays high.
- Minimum gap from one accept to the next is N cycles.

## Test plan
- Reset: hold Rstn=0 for 2 edges with Valido=1 and Dado=8'hFF -> Pronto=1, Ocupado=0, Saida=0 after reset release, and no word accepted.
- Single word: N=8, Dado=8'hA5 accepted at edge 0 -> Saida over cycles 1..8 = 1,0,1,0,0,1,0,1; Fim only in cycle 8; Pronto=1 from cycle 9.
- Back-to-back: Valido held high with 8'h01 then 8'h80 -> 16 consecutive SaidaValida cycles = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; Pronto=1 exactly in cycles 0, 8 and 16.
- Pause: Dado=8'h0F with Pausa=1 in cycles 3-4 and cycle 8 -> SaidaValida low in those cycles, Saida frozen, Fim in cycle 11 only.
- Mid-word reset: Rstn=0 at the edge ending cycle 4 of word 8'hFF -> no Fim; OCIOSO, Pronto=1 and Saida=0 from cycle 5; a new word 8'h3C then serializes correctly.
- Parameter N=2: Dado=2'b10 -> Saida 0 then 1; Fim in the second bit cycle; the counter never exceeds 1.
